nabp_multibank_swap_control: RTL and testbench

NABP_MULTIBANK_SWAP_CONTROL -- requirements
Module: nabp_multibank_swap_control

---
 rtl/nabp_multibank_swap_control_pkg.sv | 16 +
 rtl/nabp_multibank_swap_control_bank_ram.sv | 39 +++
 rtl/nabp_multibank_swap_control.sv | 146 ++++++++++++++
 tb/tb_nabp_multibank_swap_control.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nabp_multibank_swap_control_pkg.sv
// Shared NABP definitions: bank lifecycle states and default sizing.
package nabp_multibank_swap_control_pkg;

  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2,
    BANK_BUSY    = 2'd3
  } bank_st_e;

  localparam int NABP_NUM_BANKS = 3;
  localparam int NABP_S_COUNT   = 256;
  localparam int NABP_DATA_W    = 16;
  localparam int NABP_ANGLE_W   = 8;

endpackage

// File: rtl/nabp_multibank_swap_control_bank_ram.sv
// Line storage for all banks: one write port, two registered read ports.
module nabp_bank_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 10,
  parameter int DEPTH  = 768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              rd_en,
  input  logic [AW-1:0]     raddr0,
  input  logic [AW-1:0]     raddr1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Reads return zero while no bank is held by the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else if (rd_en) begin
      rdata0 <= mem[raddr0];
      rdata1 <= mem[raddr1];
    end else begin
      rdata0 <= '0;
      rdata1 <= '0;
    end
  end

endmodule

// File: rtl/nabp_multibank_swap_control.sv
// Ring of filtered-line banks handed from the filter to the projector.
module nabp_multibank_swap_control
  import nabp_multibank_swap_control_pkg::*;
#(
  parameter int NUM_BANKS = NABP_NUM_BANKS,
  parameter int S_COUNT   = NABP_S_COUNT,
  parameter int DATA_W    = NABP_DATA_W,
  parameter int ANGLE_W   = NABP_ANGLE_W,
  localparam int S_W      = $clog2(S_COUNT),
  localparam int CNT_W    = $clog2(NUM_BANKS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               hs_has_next_angle,
  input  logic [ANGLE_W-1:0] hs_angle,
  input  logic               hs_valid,
  input  logic [DATA_W-1:0]  hs_val,
  output logic               hs_next_angle,
  output logic [S_W-1:0]     hs_s_val,
  output logic               hs_filling,
  input  logic               pr_next_angle,
  input  logic               pr_prev_angle_release,
  input  logic [S_W-1:0]     pr0_s_val,
  input  logic [S_W-1:0]     pr1_s_val,
  output logic               pr_has_next_angle,
  output logic [ANGLE_W-1:0] pr_angle,
  output logic               pr_next_angle_ack,
  output logic               pr_prev_angle_release_ack,
  output logic [DATA_W-1:0]  pr0_val,
  output logic [DATA_W-1:0]  pr1_val,
  output logic [CNT_W-1:0]   free_count,
  output logic               err_proto
);

  localparam int BK_W = $clog2(NUM_BANKS);
  localparam int AW   = BK_W + S_W;

  bank_st_e           bank_st  [NUM_BANKS];
  logic [ANGLE_W-1:0] bank_tag [NUM_BANKS];

  logic [BK_W-1:0] fill_ptr;
  logic [BK_W-1:0] claim_ptr;
  logic [BK_W-1:0] release_ptr;
  logic [BK_W-1:0] cur_bank;

  logic fill_go;
  logic wr_go;
  logic wr_last;
  logic claim_ok;
  logic rel_ok;
  logic any_busy;

  function automatic logic [BK_W-1:0] bump(input logic [BK_W-1:0] p);
    return (p == BK_W'(NUM_BANKS - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fill_go  = hs_has_next_angle && !hs_filling
                 && (bank_st[fill_ptr] == BANK_FREE);
  assign wr_go    = hs_filling && hs_valid;
  assign wr_last  = wr_go && (hs_s_val == S_W'(S_COUNT - 1));
  assign claim_ok = pr_next_angle
                 && (bank_st[claim_ptr] == BANK_FULL);
  assign rel_ok   = pr_prev_angle_release
                 && (bank_st[release_ptr] == BANK_BUSY);

  assign pr_has_next_angle = (bank_st[claim_ptr] == BANK_FULL);
  assign pr_angle          = bank_tag[claim_ptr];

  always_comb begin
    any_busy = 1'b0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_st[i] == BANK_BUSY) any_busy = 1'b1;
    end
  end

  // Each update below touches a bank in a distinct state, so they never collide.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        bank_st[i]  <= BANK_FREE;
        bank_tag[i] <= '0;
      end
      fill_ptr                  <= '0;
      claim_ptr                 <= '0;
      release_ptr               <= '0;
      cur_bank                  <= '0;
      hs_filling                <= 1'b0;
      hs_s_val                  <= '0;
      hs_next_angle             <= 1'b0;
      pr_next_angle_ack         <= 1'b0;
      pr_prev_angle_release_ack <= 1'b0;
      err_proto                 <= 1'b0;
      free_count                <= CNT_W'(NUM_BANKS);
    end else begin
      hs_next_angle             <= fill_go;
      pr_next_angle_ack         <= claim_ok;
      pr_prev_angle_release_ack <= rel_ok;
      free_count <= free_count - CNT_W'(fill_go) + CNT_W'(rel_ok);
      if ((pr_next_angle && !claim_ok)
          || (pr_prev_angle_release && !rel_ok)) begin
        err_proto <= 1'b1;
      end
      if (fill_go) begin
        bank_st[fill_ptr]  <= BANK_FILLING;
        bank_tag[fill_ptr] <= hs_angle;
        hs_filling         <= 1'b1;
        hs_s_val           <= '0;
      end
      if (wr_go) begin
        hs_s_val <= hs_s_val + 1'b1;
        if (wr_last) begin
          bank_st[fill_ptr] <= BANK_FULL;
          hs_filling        <= 1'b0;
          fill_ptr          <= bump(fill_ptr);
        end
      end
      if (claim_ok) begin
        bank_st[claim_ptr] <= BANK_BUSY;
        cur_bank           <= claim_ptr;
        claim_ptr          <= bump(claim_ptr);
      end
      if (rel_ok) begin
        bank_st[release_ptr] <= BANK_FREE;
        release_ptr          <= bump(release_ptr);
      end
    end
  end

  nabp_bank_ram #(
    .DATA_W (DATA_W),
    .AW     (AW),
    .DEPTH  (NUM_BANKS * S_COUNT)
  ) u_ram (
    .clk    (clk),
    .rst_n  (reset_n),
    .we     (wr_go),
    .waddr  ({fill_ptr, hs_s_val}),
    .wdata  (hs_val),
    .rd_en  (any_busy),
    .raddr0 ({cur_bank, pr0_s_val}),
    .raddr1 ({cur_bank, pr1_s_val}),
    .rdata0 (pr0_val),
    .rdata1 (pr1_val)
  );

endmodule

// File: tb/tb_nabp_multibank_swap_control.sv
// Directed and random checks of the bank ring against a queue-based model.
module tb_nabp_multibank_swap_control;

  localparam int NB = 3;
  localparam int SC = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        hs_has_next_angle = 1'b0;
  logic [7:0]  hs_angle = '0;
  logic        hs_valid = 1'b0;
  logic [15:0] hs_val = '0;
  logic        hs_next_angle;
  logic [7:0]  hs_s_val;
  logic        hs_filling;
  logic        pr_next_angle = 1'b0;
  logic        pr_prev_angle_release = 1'b0;
  logic [7:0]  pr0_s_val = '0;
  logic [7:0]  pr1_s_val = '0;
  logic        pr_has_next_angle;
  logic [7:0]  pr_angle;
  logic        pr_next_angle_ack;
  logic        pr_prev_angle_release_ack;
  logic [15:0] pr0_val;
  logic [15:0] pr1_val;
  logic [1:0]  free_count;
  logic        err_proto;

  nabp_multibank_swap_control dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .hs_has_next_angle         (hs_has_next_angle),
    .hs_angle                  (hs_angle),
    .hs_valid                  (hs_valid),
    .hs_val                    (hs_val),
    .hs_next_angle             (hs_next_angle),
    .hs_s_val                  (hs_s_val),
    .hs_filling                (hs_filling),
    .pr_next_angle             (pr_next_angle),
    .pr_prev_angle_release     (pr_prev_angle_release),
    .pr0_s_val                 (pr0_s_val),
    .pr1_s_val                 (pr1_s_val),
    .pr_has_next_angle         (pr_has_next_angle),
    .pr_angle                  (pr_angle),
    .pr_next_angle_ack         (pr_next_angle_ack),
    .pr_prev_angle_release_ack (pr_prev_angle_release_ack),
    .pr0_val                   (pr0_val),
    .pr1_val                   (pr1_val),
    .free_count                (free_count),
    .err_proto                 (err_proto)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Model: lines are ids; full/busy lines are FIFOs in arrival order.
  logic [15:0] store [16*SC];
  logic [7:0]  ang_of [16];
  int          full_q[$];
  int          busy_q[$];
  int          m_free;
  bit          m_filling;
  int          m_idx;
  int          fill_id;
  int          next_id = 0;
  int          cur;
  bit          m_err;
  bit          e_hna, e_cack, e_rack;
  logic [15:0] e_pr0, e_pr1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    full_q.delete();
    busy_q.delete();
    m_free = NB;
    m_filling = 0;
    m_idx = 0;
    cur = 0;
    m_err = 0;
    e_hna = 0;
    e_cack = 0;
    e_rack = 0;
    e_pr0 = '0;
    e_pr1 = '0;
  endtask

  task automatic model_step();
    bit c_ok, r_ok, f_go;
    c_ok = pr_next_angle && (full_q.size() > 0);
    r_ok = pr_prev_angle_release && (busy_q.size() > 0);
    f_go = hs_has_next_angle && !m_filling && (m_free > 0);
    if (busy_q.size() > 0) begin
      e_pr0 = store[cur*SC + int'(pr0_s_val)];
      e_pr1 = store[cur*SC + int'(pr1_s_val)];
    end else begin
      e_pr0 = '0;
      e_pr1 = '0;
    end
    e_hna  = f_go;
    e_cack = c_ok;
    e_rack = r_ok;
    if ((pr_next_angle && !c_ok) || (pr_prev_angle_release && !r_ok))
      m_err = 1;
    if (r_ok) begin
      void'(busy_q.pop_front());
      m_free++;
    end
    if (c_ok) begin
      cur = full_q.pop_front();
      busy_q.push_back(cur);
    end
    if (m_filling && hs_valid) begin
      store[fill_id*SC + m_idx] = hs_val;
      m_idx++;
      if (m_idx == SC) begin
        m_idx = 0;
        m_filling = 0;
        full_q.push_back(fill_id);
      end
    end
    if (f_go) begin
      m_free--;
      m_filling = 1;
      m_idx = 0;
      fill_id = next_id;
      next_id = (next_id + 1) % 16;
      ang_of[fill_id] = hs_angle;
    end
  endtask

  task automatic check_all();
    chk("hs_next_angle", hs_next_angle, e_hna);
    chk("hs_filling", hs_filling, m_filling);
    chk("hs_s_val", hs_s_val, m_idx);
    chk("pr_has_next_angle", pr_has_next_angle, full_q.size() > 0);
    if (full_q.size() > 0) chk("pr_angle", pr_angle, ang_of[full_q[0]]);
    chk("claim_ack", pr_next_angle_ack, e_cack);
    chk("release_ack", pr_prev_angle_release_ack, e_rack);
    chk("pr0_val", pr0_val, e_pr0);
    chk("pr1_val", pr1_val, e_pr1);
    chk("free_count", free_count, m_free);
    chk("err_proto", err_proto, m_err);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic clear_inputs();
    hs_has_next_angle = 0;
    hs_valid = 0;
    pr_next_angle = 0;
    pr_prev_angle_release = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_all();
    reset_n = 1;
  endtask

  // Start a fill and feed samples until stop_at written (SC = complete line).
  task automatic fill(input logic [7:0] ang, input bit gap,
                      input bit rnd, input int stop_at);
    int n;
    n = 0;
    hs_has_next_angle = 1;
    hs_angle = ang;
    while (!m_filling && n < 50) begin
      cycle();
      n++;
    end
    hs_has_next_angle = 0;
    chk("fill_start", hs_filling, 1'b1);
    n = 0;
    while (m_filling && m_idx < stop_at && n < 2000) begin
      hs_valid = gap ? (n % 2 == 0) : 1'b1;
      hs_val = rnd ? 16'($urandom) : 16'(m_idx);
      cycle();
      n++;
    end
    hs_valid = 0;
    if (stop_at >= SC) chk("fill_done", hs_filling, 1'b0);
  endtask

  task automatic claim();
    pr_next_angle = 1;
    cycle();
    pr_next_angle = 0;
  endtask

  task automatic release_bank();
    pr_prev_angle_release = 1;
    cycle();
    pr_prev_angle_release = 0;
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int nv;
    int fc;
    @(negedge clk);
    do_reset();
    chk("reset_free_count", free_count, 2'd3);

    // Single line with sample = index, then dual read.
    fill(8'd5, 0, 0, SC);
    chk("line5_has", pr_has_next_angle, 1'b1);
    chk("line5_angle", pr_angle, 8'd5);
    chk("line5_free", free_count, 2'd2);
    claim();
    pr0_s_val = 8'd0;
    pr1_s_val = 8'd255;
    cycle();
    chk("read_idx0", pr0_val, 16'd0);
    chk("read_idx255", pr1_val, 16'd255);
    release_bank();

    // Ring full: fourth offer waits for a release.
    do_reset();
    for (int a = 1; a <= 3; a++) fill(8'(a), 0, 1, SC);
    hs_has_next_angle = 1;
    hs_angle = 8'd4;
    for (int i = 0; i < 8; i++) begin
      cycle();
      chk("ring_full_no_start", hs_next_angle, 1'b0);
    end
    hs_has_next_angle = 0;
    for (int a = 1; a <= 3; a++) begin
      chk("claim_order", pr_angle, 32'(a));
      claim();
      pr0_s_val = 8'($urandom);
      pr1_s_val = 8'($urandom);
      cycle();
    end
    release_bank();
    fill(8'd4, 0, 1, SC);

    // Claim with nothing full sets a sticky error.
    do_reset();
    claim();
    chk("err_no_ack", pr_next_angle_ack, 1'b0);
    chk("err_set", err_proto, 1'b1);
    for (int i = 0; i < 4; i++) cycle();
    chk("err_sticky", err_proto, 1'b1);

    // Same-cycle claim and release.
    do_reset();
    fill(8'd10, 0, 1, SC);
    fill(8'd11, 0, 1, SC);
    claim();
    fc = int'(free_count);
    pr_next_angle = 1;
    pr_prev_angle_release = 1;
    cycle();
    clear_inputs();
    chk("both_claim_ack", pr_next_angle_ack, 1'b1);
    chk("both_release_ack", pr_prev_angle_release_ack, 1'b1);
    chk("both_free_inc", free_count, fc + 1);

    // Reset in the middle of a fill abandons it.
    do_reset();
    fill(8'd20, 0, 1, 100);
    do_reset();
    chk("abort_filling", hs_filling, 1'b0);
    chk("abort_free", free_count, 2'd3);
    chk("abort_has", pr_has_next_angle, 1'b0);
    fill(8'd21, 0, 0, SC);
    chk("refill_angle", pr_angle, 8'd21);
    claim();
    pr0_s_val = 8'd100;
    pr1_s_val = 8'd7;
    cycle();
    chk("refill_read0", pr0_val, 16'd100);
    chk("refill_read1", pr1_val, 16'd7);

    // Valid gaps: exactly SC valid samples complete the line.
    do_reset();
    hs_has_next_angle = 1;
    hs_angle = 8'd33;
    cycle();
    hs_has_next_angle = 0;
    nv = 0;
    for (int n = 0; n < 2000 && m_filling; n++) begin
      hs_valid = (n % 2 == 1);
      hs_val = 16'($urandom);
      if (hs_valid) nv++;
      cycle();
    end
    hs_valid = 0;
    chk("gap_valid_count", nv, SC);
    chk("gap_full", pr_has_next_angle, 1'b1);

    // Random traffic on both sides.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      hs_has_next_angle = ($urandom % 4) != 0;
      hs_angle = 8'($urandom);
      hs_valid = ($urandom % 3) != 0;
      hs_val = 16'($urandom);
      pr_next_angle = ($urandom % 24) == 0;
      pr_prev_angle_release = ($urandom % 30) == 0;
      pr0_s_val = 8'($urandom);
      pr1_s_val = 8'($urandom);
      cycle();
    end
    clear_inputs();
    cycle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
